lsu_read_arbiter_ooo: RTL and testbench
=======================================

Name: lsu_read_arbiter_ooo

Overview:
- Multi-LSU read arbiter that can keep several reads in flight to global memory at once.
- Grants one memory read per cycle using round-robin or fixed priority.
- Coalesces same-address requests from different LSUs into one memory read.
- Tracks in-flight reads in an in-order tag FIFO and routes each returning word to every LSU that asked for it.
- Sits between the LSU read ports and the single global-memory read port.

Parameters:
- D_WIDTH, 32, data word width.
- INTERFACE_ADDR_WIDTH, 32, address width.
- NUM_LSU, 4, number of LSU read ports (>=2).
- MAX_OUTSTANDING, 4, tag FIFO depth; power of two, >=2.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- COALESCE, 1, 1 = merge same-address requesters into one read; 0 = winner only.

Ports:
- iClk  in  1  clock.
- iReset_n  in  1  asynchronous active-low reset.
- iReadAddress  in  NUM_LSU*INTERFACE_ADDR_WIDTH  per-LSU read address; port p occupies slice p.
- iReadRequest  in  NUM_LSU  per-LSU read request, level; held until accepted.
- oReadAccept  out  NUM_LSU  per-LSU single-cycle accept pulse.
- oReadData  out  NUM_LSU*D_WIDTH  per-LSU returned data.
- oReadDataValid  out  NUM_LSU  per-LSU data-valid pulse.
- oReadAddress  out  INTERFACE_ADDR_WIDTH  memory read address.
- oReadRequest  out  1  memory read request.
- iReadAccept  in  1  memory accepts the request this cycle.
- iReadData  in  D_WIDTH  memory read data.
- iReadDataValid  in  1  memory data valid; responses return in issue order.
- oOutstanding  out  clog2(MAX_OUTSTANDING+1)  current tag FIFO occupancy.
- oError  out  1  sticky error flag.

Behaviour:
- Reset (async assert, sync-release-safe):
  - all outputs 0;
  - pending[] = 0, FIFO empty, count = 0;
  - RR pointer = port 0; oError = 0.
- Eligibility: elig[p] = iReadRequest[p] & !pending[p]. Each LSU has at most one read outstanding.
- Winner selection (combinational from elig and pointer):
  - RR: first eligible port searching from the pointer upward with wrap.
  - Fixed: lowest eligible index.
- Issue (combinational):
  - oReadRequest = |elig & (count < MAX_OUTSTANDING).
  - oReadAddress = winner's address; 0 when no winner.
- Grant mask:
  - COALESCE=1: mask = winner | every eligible port whose address equals the winner's.
  - COALESCE=0: mask = winner.
- Accept occurs when oReadRequest & iReadAccept. In that cycle:
  - oReadAccept = mask, combinationally;
  - at the clock edge: mask is pushed into the FIFO, pending |= mask, and the RR pointer moves to winner+1 mod NUM_LSU.
  - If iReadAccept is low, nothing changes and the request holds.
- Response on iReadDataValid with FIFO non-empty:
  - at the clock edge, pop the head mask m;
  - register oReadData[p] = iReadData for all p;
  - register oReadDataValid = m;
  - pending &= ~m.
  - Total latency is exactly 1 cycle from iReadDataValid to oReadDataValid.
  - A port whose oReadDataValid is high is eligible in that same cycle.
- Response on iReadDataValid with FIFO empty: data is dropped, oReadDataValid stays 0, oError is set and stays set until reset.
- Push and pop in the same cycle: count unchanged, both operations performed.
  - Issue while full is blocked even if a pop occurs the same cycle.
- A pending port is excluded from arbitration even if its iReadRequest stays high.
- oOutstanding = count, registered.
- Reset mid-operation: in-flight FIFO contents are discarded. Later memory responses set oError.

Test Plan:
- Single read: port 2 requests A=0x40, iReadAccept=1.
  - Same cycle: oReadAccept=0100.
  - Next cycle: oOutstanding=1.
  - iReadDataValid with 0xDEADBEEF gives oReadDataValid=0100 and oReadData[2]=0xDEADBEEF one cycle later; oOutstanding=0.
- Round-robin fairness: all 4 ports request distinct addresses continuously; the memory accepts every cycle and returns data 2 cycles after each accept.
  - Accept order is 0,1,2,3 after reset.
  - No port is accepted twice before the other three.
- Coalescing: ports 0 and 3 both request 0x100, port 1 requests 0x200.
  - First accept: mask 1001, one memory read.
  - Its response raises oReadDataValid=1001.
  - COALESCE=0 on the same stimulus: three separate reads.
- Full FIFO: MAX_OUTSTANDING=4 with no responses.
  - After 4 accepts, oReadRequest=0 and oOutstanding=4.
  - A response and a new request in the same cycle: no issue that cycle; issue the next cycle, with count going 4, 3, 4.
- Fixed priority: ARB_MODE=1 with ports 1 and 3 requesting; port 1 always wins until it becomes pending; port 3 is then served.
- Error/reset: iReadDataValid with the FIFO empty sets oError=1 and oReadDataValid=0. Asserting iReset_n low clears oError asynchronously.

Source files
------------

// File: rtl/lsu_read_arbiter_ooo.sv
// Multi-LSU read arbiter: grants one global-memory read per cycle, merges same-address
// requesters, and routes in-order responses back through a tag FIFO of grant masks.
module lsu_read_arbiter_ooo #(
    parameter int D_WIDTH              = 32,
    parameter int INTERFACE_ADDR_WIDTH = 32,
    parameter int NUM_LSU              = 4,
    parameter int MAX_OUTSTANDING      = 4,
    parameter int ARB_MODE             = 0,
    parameter int COALESCE             = 1
) (
    input  logic                                    iClk,
    input  logic                                    iReset_n,
    input  logic [NUM_LSU*INTERFACE_ADDR_WIDTH-1:0] iReadAddress,
    input  logic [NUM_LSU-1:0]                      iReadRequest,
    output logic [NUM_LSU-1:0]                      oReadAccept,
    output logic [NUM_LSU*D_WIDTH-1:0]              oReadData,
    output logic [NUM_LSU-1:0]                      oReadDataValid,
    output logic [INTERFACE_ADDR_WIDTH-1:0]         oReadAddress,
    output logic                                    oReadRequest,
    input  logic                                    iReadAccept,
    input  logic [D_WIDTH-1:0]                      iReadData,
    input  logic                                    iReadDataValid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    oOutstanding,
    output logic                                    oError
);

    localparam int AW    = INTERFACE_ADDR_WIDTH;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int IDX_W = $clog2(NUM_LSU);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_LSU - 1);
    localparam logic [IDX_W:0]   NUM_LSU_W = (IDX_W + 1)'(NUM_LSU);

    typedef logic [NUM_LSU-1:0] lsu_mask_t;

    lsu_mask_t          tag_mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    lsu_mask_t          pending_q, pending_d;
    lsu_mask_t          rvalid_q, rvalid_d;
    logic [D_WIDTH-1:0] rdata_q, rdata_d;
    logic               error_q, error_d;

    lsu_mask_t          elig;
    lsu_mask_t          addr_match;
    lsu_mask_t          grant_mask;
    lsu_mask_t          head_mask;
    logic               have_winner;
    logic [IDX_W-1:0]   winner_idx;
    logic [IDX_W:0]     cand;
    logic [AW-1:0]      win_addr;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    // Winner selection, winner address and the coalesced grant mask.
    // NOTE: every variable gets a default at the top of the block so no latch is inferred.
    always_comb begin
        elig        = iReadRequest & ~pending_q;
        have_winner = 1'b0;
        winner_idx  = '0;
        cand        = '0;
        win_addr    = '0;
        addr_match  = '0;
        grant_mask  = '0;

        if (ARB_MODE == 1) begin
            for (int i = NUM_LSU - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    have_winner = 1'b1;
                    winner_idx  = IDX_W'(i);
                end
            end
        end else begin
            // Scan downward so the closest eligible port above the pointer is written last.
            for (int k = NUM_LSU - 1; k >= 0; k--) begin
                cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
                if (cand >= NUM_LSU_W) cand = cand - NUM_LSU_W;
                if (elig[cand[IDX_W-1:0]]) begin
                    have_winner = 1'b1;
                    winner_idx  = cand[IDX_W-1:0];
                end
            end
        end

        for (int p = 0; p < NUM_LSU; p++) begin
            if (have_winner && (IDX_W'(p) == winner_idx)) win_addr = iReadAddress[p*AW +: AW];
        end

        for (int p = 0; p < NUM_LSU; p++) begin
            if (elig[p] && (iReadAddress[p*AW +: AW] == win_addr)) addr_match[p] = 1'b1;
        end

        if (have_winner) begin
            grant_mask[winner_idx] = 1'b1;
            if (COALESCE == 1) grant_mask = grant_mask | addr_match;
        end
    end

    assign fifo_empty     = (count_q == '0);
    assign oReadRequest   = (|elig) & (count_q < CNT_FULL);
    assign oReadAddress   = win_addr;
    assign push           = oReadRequest & iReadAccept;
    assign pop            = iReadDataValid & ~fifo_empty;
    assign oReadAccept    = push ? grant_mask : '0;
    assign head_mask      = tag_mem_q[rd_ptr_q];
    assign oReadData      = {NUM_LSU{rdata_q}};
    assign oReadDataValid = rvalid_q;
    assign oOutstanding   = count_q;
    assign oError         = error_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rr_ptr_d  = rr_ptr_q;
        pending_d = pending_q;
        rvalid_d  = '0;
        rdata_d   = rdata_q;
        error_d   = error_q;

        if (push) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            pending_d = pending_d | grant_mask;
            rr_ptr_d  = (winner_idx == IDX_LAST) ? '0 : winner_idx + 1'b1;
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            pending_d = pending_d & ~head_mask;
            rvalid_d  = head_mask;
            rdata_d   = iReadData;
        end

        // A response with nothing in flight has no owner; drop it and flag it.
        if (iReadDataValid && fifo_empty) error_d = 1'b1;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rr_ptr_q  <= '0;
            pending_q <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
        end
    end

    // NOTE: tag storage has no reset; count and pointers alone decide which entries are live.
    always_ff @(posedge iClk) begin
        if (push) tag_mem_q[wr_ptr_q] <= grant_mask;
    end

endmodule

// File: tb/tb_lsu_read_arbiter_ooo.sv
// Bench for lsu_read_arbiter_ooo: directed vector table on two configurations plus
// model-checked round-robin fairness and random traffic on the default configuration.
module tb_lsu_read_arbiter_ooo;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: defaults (round-robin, coalescing, 4 outstanding)
    logic [N*AW-1:0] a_addr;
    logic [N-1:0]    a_req, a_acc, a_rdv;
    logic            a_macc, a_dv, a_mreq, a_err;
    logic [DW-1:0]   a_data;
    logic [N*DW-1:0] a_rdata;
    logic [AW-1:0]   a_maddr;
    logic [2:0]      a_cnt;

    // DUT B: fixed priority, no coalescing, 2 outstanding
    logic [N*AW-1:0] b_addr;
    logic [N-1:0]    b_req, b_acc, b_rdv;
    logic            b_macc, b_dv, b_mreq, b_err;
    logic [DW-1:0]   b_data;
    logic [N*DW-1:0] b_rdata;
    logic [AW-1:0]   b_maddr;
    logic [1:0]      b_cnt;

    lsu_read_arbiter_ooo u_dut_a (
        .iClk(clk), .iReset_n(rst_n),
        .iReadAddress(a_addr), .iReadRequest(a_req), .oReadAccept(a_acc),
        .oReadData(a_rdata), .oReadDataValid(a_rdv),
        .oReadAddress(a_maddr), .oReadRequest(a_mreq), .iReadAccept(a_macc),
        .iReadData(a_data), .iReadDataValid(a_dv),
        .oOutstanding(a_cnt), .oError(a_err)
    );

    lsu_read_arbiter_ooo #(.MAX_OUTSTANDING(2), .ARB_MODE(1), .COALESCE(0)) u_dut_b (
        .iClk(clk), .iReset_n(rst_n),
        .iReadAddress(b_addr), .iReadRequest(b_req), .oReadAccept(b_acc),
        .oReadData(b_rdata), .oReadDataValid(b_rdv),
        .oReadAddress(b_maddr), .oReadRequest(b_mreq), .iReadAccept(b_macc),
        .iReadData(b_data), .iReadDataValid(b_dv),
        .oOutstanding(b_cnt), .oError(b_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*AW-1:0] ad(input logic [AW-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    typedef struct {
        logic            sel;
        logic [N-1:0]    req;
        logic [N*AW-1:0] addr;
        logic            macc;
        logic            dv;
        logic [DW-1:0]   data;
        logic [N-1:0]    e_acc;
        logic            e_mreq;
        logic [AW-1:0]   e_maddr;
        int              e_cnt;
        logic [N-1:0]    e_rdv;
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    task automatic add_vec(input logic sel, input logic [N-1:0] req, input logic [N*AW-1:0] addr,
                           input logic macc, input logic dv, input logic [DW-1:0] data,
                           input logic [N-1:0] e_acc, input logic e_mreq, input logic [AW-1:0] e_maddr,
                           input int e_cnt, input logic [N-1:0] e_rdv);
        vec_t t;
        t.sel = sel; t.req = req; t.addr = addr; t.macc = macc; t.dv = dv; t.data = data;
        t.e_acc = e_acc; t.e_mreq = e_mreq; t.e_maddr = e_maddr; t.e_cnt = e_cnt; t.e_rdv = e_rdv;
        vecs.push_back(t);
    endtask

    task automatic idle_all();
        a_req = '0; a_addr = '0; a_macc = 1'b0; a_dv = 1'b0; a_data = '0;
        b_req = '0; b_addr = '0; b_macc = 1'b0; b_dv = 1'b0; b_data = '0;
    endtask

    // Reference model of DUT A: set of pending ports, queue of in-flight grant masks.
    logic [N-1:0]  m_pend;
    logic [N-1:0]  m_q[$];
    int            m_rr;
    logic          m_err;
    logic [N-1:0]  m_rdv;
    logic [DW-1:0] m_rdata;

    task automatic model_reset();
        m_pend = '0; m_q.delete(); m_rr = 0; m_err = 1'b0; m_rdv = '0; m_rdata = '0;
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    // One cycle on DUT A, entered and left at a falling edge.
    task automatic step(input logic [N-1:0] req, input logic [N*AW-1:0] addr, input logic macc,
                        input logic dv, input logic [DW-1:0] data, output logic [N-1:0] acc_seen);
        logic [N-1:0]  elig, mask;
        logic [AW-1:0] waddr;
        logic          issue;
        int            win;
        check("m_cnt", 128'(a_cnt), 128'(m_q.size()));
        check("m_rdv", 128'(a_rdv), 128'(m_rdv));
        check("m_rdata", 128'(a_rdata), 128'({N{m_rdata}}));
        check("m_err", 128'(a_err), 128'(m_err));
        a_req = req; a_addr = addr; a_macc = macc; a_dv = dv; a_data = data;
        #1;
        elig = req & ~m_pend;
        win  = -1;
        for (int k = 0; k < N; k++) begin
            if (win < 0 && elig[(m_rr + k) % N]) win = (m_rr + k) % N;
        end
        issue = (elig != '0) && (m_q.size() < 4);
        waddr = (win >= 0) ? addr[win*AW +: AW] : '0;
        mask  = '0;
        if (win >= 0) begin
            for (int p = 0; p < N; p++) begin
                if (elig[p] && addr[p*AW +: AW] == waddr) mask[p] = 1'b1;
            end
        end
        check("m_mreq", 128'(a_mreq), 128'(issue));
        check("m_maddr", 128'(a_maddr), 128'(waddr));
        check("m_acc", 128'(a_acc), 128'((issue && macc) ? mask : 4'b0));
        acc_seen = a_acc;
        m_rdv = '0;
        if (dv) begin
            if (m_q.size() > 0) begin
                m_rdv   = m_q.pop_front();
                m_rdata = data;
                m_pend  = m_pend & ~m_rdv;
            end else begin
                m_err = 1'b1;
            end
        end
        if (issue && macc) begin
            m_q.push_back(mask);
            m_pend = m_pend | mask;
            m_rr   = (win + 1) % N;
        end
        @(negedge clk);
    endtask

    logic [N*AW-1:0] dflt, coal, fixp, r_addr;
    logic [N-1:0]    acc_seen, r_req, r_acc;
    logic            r_dv;
    int              due[$];
    int              ord[$];
    int              bad_win;
    logic [N-1:0]    seen;

    initial begin
        idle_all();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_acc", 128'(a_acc), 128'(0));
        check("rst_rdv", 128'(a_rdv), 128'(0));
        check("rst_rdata", 128'(a_rdata), 128'(0));
        check("rst_maddr", 128'(a_maddr), 128'(0));
        check("rst_mreq", 128'(a_mreq), 128'(0));
        check("rst_cnt", 128'(a_cnt), 128'(0));
        check("rst_err", 128'(a_err), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        dflt = ad(32'h1000, 32'h1010, 32'h1020, 32'h1030);
        coal = ad(32'h100, 32'h200, 32'h1020, 32'h100);
        fixp = ad(32'h1000, 32'h300, 32'h1020, 32'h500);

        // DUT A: single read, then fill to 4, pop+request collision, drain
        add_vec(L, 4'b0100, ad(32'h0, 32'h0, 32'h40, 32'h0), H, L, 32'h0, 4'b0100, H, 32'h40, 1, 4'b0000);
        add_vec(L, 4'b0000, dflt, L, L, 32'h0,        4'b0000, L, 32'h0,    1, 4'b0000);
        add_vec(L, 4'b0000, dflt, L, H, 32'hDEADBEEF, 4'b0000, L, 32'h0,    0, 4'b0100);
        add_vec(L, 4'b1111, dflt, H, L, 32'h0,        4'b1000, H, 32'h1030, 1, 4'b0000);
        add_vec(L, 4'b1111, dflt, H, L, 32'h0,        4'b0001, H, 32'h1000, 2, 4'b0000);
        add_vec(L, 4'b1111, dflt, H, L, 32'h0,        4'b0010, H, 32'h1010, 3, 4'b0000);
        add_vec(L, 4'b1111, dflt, H, L, 32'h0,        4'b0100, H, 32'h1020, 4, 4'b0000);
        add_vec(L, 4'b1111, dflt, H, H, 32'h11111111, 4'b0000, L, 32'h0,    3, 4'b1000);
        add_vec(L, 4'b1111, dflt, H, L, 32'h0,        4'b1000, H, 32'h1030, 4, 4'b0000);
        add_vec(L, 4'b0000, dflt, L, H, 32'h22222222, 4'b0000, L, 32'h0,    3, 4'b0001);
        add_vec(L, 4'b0000, dflt, L, H, 32'h33333333, 4'b0000, L, 32'h0,    2, 4'b0010);
        add_vec(L, 4'b0000, dflt, L, H, 32'h44444444, 4'b0000, L, 32'h0,    1, 4'b0100);
        add_vec(L, 4'b0000, dflt, L, H, 32'h55555555, 4'b0000, L, 32'h0,    0, 4'b1000);
        // DUT A: coalescing of ports 0 and 3
        add_vec(L, 4'b1011, coal, H, L, 32'h0,        4'b1001, H, 32'h100,  1, 4'b0000);
        add_vec(L, 4'b1011, coal, H, L, 32'h0,        4'b0010, H, 32'h200,  2, 4'b0000);
        add_vec(L, 4'b0000, coal, L, H, 32'hAAAA0000, 4'b0000, L, 32'h0,    1, 4'b1001);
        add_vec(L, 4'b0000, coal, L, H, 32'hBBBB0000, 4'b0000, L, 32'h0,    0, 4'b0010);
        // DUT A: memory stall, then re-eligibility in the data-valid cycle
        add_vec(L, 4'b0001, dflt, L, L, 32'h0,        4'b0000, H, 32'h1000, 0, 4'b0000);
        add_vec(L, 4'b0001, dflt, H, L, 32'h0,        4'b0001, H, 32'h1000, 1, 4'b0000);
        add_vec(L, 4'b0001, dflt, H, H, 32'h66666666, 4'b0000, L, 32'h0,    0, 4'b0001);
        add_vec(L, 4'b0001, dflt, H, L, 32'h0,        4'b0001, H, 32'h1000, 1, 4'b0000);
        add_vec(L, 4'b0000, dflt, L, H, 32'h77777777, 4'b0000, L, 32'h0,    0, 4'b0001);
        // DUT B: no coalescing, full at 2 with pop+request collision
        add_vec(H, 4'b1011, coal, H, L, 32'h0,        4'b0001, H, 32'h100,  1, 4'b0000);
        add_vec(H, 4'b1010, coal, H, L, 32'h0,        4'b0010, H, 32'h200,  2, 4'b0000);
        add_vec(H, 4'b1000, coal, H, H, 32'h12345678, 4'b0000, L, 32'h100,  1, 4'b0001);
        add_vec(H, 4'b1000, coal, H, L, 32'h0,        4'b1000, H, 32'h100,  2, 4'b0000);
        add_vec(H, 4'b0000, coal, L, H, 32'h9ABCDEF0, 4'b0000, L, 32'h0,    1, 4'b0010);
        add_vec(H, 4'b0000, coal, L, H, 32'h0F0F0F0F, 4'b0000, L, 32'h0,    0, 4'b1000);
        // DUT B: fixed priority between ports 1 and 3
        add_vec(H, 4'b1010, fixp, L, L, 32'h0,        4'b0000, H, 32'h300,  0, 4'b0000);
        add_vec(H, 4'b1010, fixp, H, L, 32'h0,        4'b0010, H, 32'h300,  1, 4'b0000);
        add_vec(H, 4'b1010, fixp, H, L, 32'h0,        4'b1000, H, 32'h500,  2, 4'b0000);
        add_vec(H, 4'b0000, fixp, L, H, 32'hCAFE0001, 4'b0000, L, 32'h0,    1, 4'b0010);
        add_vec(H, 4'b0000, fixp, L, H, 32'hCAFE0002, 4'b0000, L, 32'h0,    0, 4'b1000);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            idle_all();
            if (v.sel) begin
                b_req = v.req; b_addr = v.addr; b_macc = v.macc; b_dv = v.dv; b_data = v.data;
            end else begin
                a_req = v.req; a_addr = v.addr; a_macc = v.macc; a_dv = v.dv; a_data = v.data;
            end
            #1;
            check($sformatf("v%0d_acc", i), 128'(v.sel ? b_acc : a_acc), 128'(v.e_acc));
            check($sformatf("v%0d_mreq", i), 128'(v.sel ? b_mreq : a_mreq), 128'(v.e_mreq));
            check($sformatf("v%0d_maddr", i), 128'(v.sel ? b_maddr : a_maddr), 128'(v.e_maddr));
            @(negedge clk);
            check($sformatf("v%0d_cnt", i), 128'(v.sel ? {1'b0, b_cnt} : a_cnt), 128'(v.e_cnt));
            check($sformatf("v%0d_rdv", i), 128'(v.sel ? b_rdv : a_rdv), 128'(v.e_rdv));
            if (v.e_rdv != '0)
                check($sformatf("v%0d_rdata", i), 128'(v.sel ? b_rdata : a_rdata), 128'({N{v.data}}));
        end
        idle_all();

        // Orphan response sets the sticky error and produces no data-valid
        a_dv = 1'b1; a_data = 32'hBAD;
        @(negedge clk);
        a_dv = 1'b0;
        check("err_set", 128'(a_err), 128'(1));
        check("err_rdv", 128'(a_rdv), 128'(0));
        check("err_b_clean", 128'(b_err), 128'(0));
        @(negedge clk);
        check("err_sticky", 128'(a_err), 128'(1));

        // Asynchronous reset with one read in flight
        a_req = 4'b0001; a_addr = dflt; a_macc = 1'b1;
        @(negedge clk);
        idle_all();
        check("inflight_cnt", 128'(a_cnt), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_err_clr", 128'(a_err), 128'(0));
        check("async_cnt_clr", 128'(a_cnt), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_dv = 1'b1; a_data = 32'h5A5A5A5A;
        @(negedge clk);
        a_dv = 1'b0;
        check("late_resp_err", 128'(a_err), 128'(1));
        check("late_resp_rdv", 128'(a_rdv), 128'(0));

        // Round-robin fairness: all ports request, data returns 2 cycles after accept
        do_reset();
        for (int c = 0; c < 24; c++) begin
            r_dv = (due.size() > 0) && (due[0] == c);
            if (r_dv) void'(due.pop_front());
            step(4'b1111, dflt, 1'b1, r_dv, $urandom, acc_seen);
            if (acc_seen != '0) begin
                due.push_back(c + 2);
                for (int p = N - 1; p >= 0; p--) if (acc_seen[p]) r_addr[31:0] = 32'(p);
                ord.push_back(int'(r_addr[31:0]));
            end
        end
        check("rr_accepts", 128'(ord.size()), 128'(24));
        for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), 128'(ord[i]), 128'(i));
        bad_win = 0;
        for (int i = 0; i + 4 <= ord.size(); i++) begin
            seen = '0;
            for (int j = 0; j < 4; j++) seen[ord[i+j]] = 1'b1;
            if (seen != 4'b1111) bad_win++;
        end
        check("rr_windows", 128'(bad_win), 128'(0));

        // Random traffic against the model
        do_reset();
        r_req = '0; r_acc = '0; r_addr = '0;
        for (int c = 0; c < 500; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!r_req[p] || r_acc[p]) begin
                    r_req[p] = ($urandom_range(0, 1) == 1);
                    r_addr[p*AW +: AW] = 32'h100 * $urandom_range(1, 3);
                end
            end
            r_dv = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
            step(r_req, r_addr, ($urandom_range(0, 3) != 0), r_dv, $urandom, r_acc);
        end
        step('0, r_addr, 1'b0, 1'b0, 32'h0, r_acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
